// File: rtl/mem_arbiter_pkg.sv
// Shared core definitions: ALU opcodes, arbiter FSM states and requester IDs.
package mem_arbiter_pkg;

    // ALU operation encoding used by the execute stage.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    // Memory arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    // Requester IDs.
    localparam logic REQ_IFU = 1'b0;
    localparam logic REQ_LSU = 1'b1;

    // Pick the requester to grant; on a tie the one not granted last wins.
    function automatic logic rr_pick(input logic ifu_v, input logic lsu_v, input logic last_grant);
        logic pick;
        if (ifu_v && lsu_v) begin
            pick = ~last_grant;
        end else if (lsu_v) begin
            pick = REQ_LSU;
        end else begin
            pick = REQ_IFU;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Response timeout counter: clears, counts enabled cycles and flags the
// cycle in which the count reaches TIMEOUT.
module mem_timeout_cnt #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // Next count: clear wins over increment.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 16'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expire in the cycle whose increment reaches TIMEOUT (17 bits avoids wrap).
    assign expire_o = en_i && (({1'b0, count_q} + 17'd1) >= 17'(TIMEOUT));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter onto a single memory port with one
// transaction outstanding, round-robin on ties, and a response timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_resp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int unsigned MASK_W = DATA_W / 8;

    arb_state_e          state_q, state_d;
    logic                last_q, last_d;
    logic                owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;

    logic                grant;
    logic                resp_v;
    logic                resp_err;
    logic [DATA_W-1:0]   resp_data;
    logic                to_expire;

    mem_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (state_q != ST_RESP),
        .en_i     ((state_q == ST_RESP) && !mem_resp_valid),
        .expire_o (to_expire)
    );

    // Next-state, latch capture and handshake/response outputs; all held at 0 in reset.
    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        owner_d        = owner_q;
        addr_d         = addr_q;
        wen_d          = wen_q;
        wdata_d        = wdata_q;
        wmask_d        = wmask_q;
        grant          = REQ_IFU;
        resp_v         = 1'b0;
        resp_err       = 1'b0;
        resp_data      = '0;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        mem_req_valid  = 1'b0;
        ifu_resp_valid = 1'b0;
        ifu_rdata      = '0;
        ifu_resp_err   = 1'b0;
        lsu_resp_valid = 1'b0;
        lsu_rdata      = '0;
        lsu_resp_err   = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (ifu_req_valid || lsu_req_valid) begin
                        grant   = rr_pick(ifu_req_valid, lsu_req_valid, last_q);
                        owner_d = grant;
                        last_d  = grant;
                        state_d = ST_REQ;
                        if (grant == REQ_LSU) begin
                            lsu_req_ready = 1'b1;
                            addr_d        = lsu_addr;
                            wen_d         = lsu_wen;
                            wdata_d       = lsu_wdata;
                            wmask_d       = lsu_wmask;
                        end else begin
                            ifu_req_ready = 1'b1;
                            addr_d        = ifu_addr;
                            wen_d         = 1'b0;
                            wdata_d       = '0;
                            wmask_d       = '0;
                        end
                    end
                end
                ST_REQ: begin
                    mem_req_valid = 1'b1;
                    if (mem_req_ready) begin
                        state_d = ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (mem_resp_valid) begin
                        resp_v    = 1'b1;
                        resp_data = mem_rdata;
                        state_d   = ST_IDLE;
                    end else if (to_expire) begin
                        resp_v    = 1'b1;
                        resp_err  = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
            if (owner_q == REQ_LSU) begin
                lsu_resp_valid = resp_v;
                lsu_rdata      = resp_data;
                lsu_resp_err   = resp_err;
            end else begin
                ifu_resp_valid = resp_v;
                ifu_rdata      = resp_data;
                ifu_resp_err   = resp_err;
            end
        end
    end

    // State, round-robin history and latched request fields.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= REQ_IFU;
            owner_q <= REQ_IFU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    assign mem_addr  = rst_n ? addr_q  : '0;
    assign mem_wen   = rst_n ? wen_q   : 1'b0;
    assign mem_wdata = rst_n ? wdata_q : '0;
    assign mem_wmask = rst_n ? wmask_q : '0;

endmodule
